// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: two-port round-robin front end for one shared sqrt core.
// One job in flight; a watchdog aborts and resets the core on a hung job.
module sqrt_arbiter #(
  parameter int W       = 16,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0,
  input  logic           req1,
  input  logic [W-1:0]   a0,
  input  logic [W-1:0]   a1,
  output logic           gnt0,
  output logic           gnt1,
  output logic [W/2-1:0] res0,
  output logic [W/2-1:0] res1,
  output logic           valid0,
  output logic           valid1,
  output logic           err0,
  output logic           err1,
  output logic           core_init,
  output logic [W-1:0]   core_a,
  output logic           core_rst,
  input  logic           core_done,
  input  logic [W/2-1:0] core_result
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    RETURN = 2'd3
  } state_t;

  localparam logic [15:0] TMAX = 16'(TIMEOUT);

  state_t      state;
  state_t      state_n;
  logic        own;
  logic        last;
  logic        pick;
  logic [15:0] cnt;
  logic [1:0]  err_q;
  logic        tmo;
  logic        take;

  assign tmo  = (state == WAIT) && (cnt == TMAX) && !core_done;
  assign take = (state == IDLE) && (state_n == ISSUE);

  // next-state and tie-break: on a tie the port not served last wins
  always_comb begin
    state_n = state;
    pick    = (req0 && req1) ? ~last : req1;
    unique case (state)
      IDLE:    if (req0 || req1) state_n = ISSUE;
      ISSUE:   state_n = WAIT;
      WAIT:    if (core_done || cnt == TMAX) state_n = RETURN;
      RETURN:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // state, owner, operand, watchdog counter and per-port results
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      own    <= 1'b0;
      last   <= 1'b1;
      cnt    <= '0;
      core_a <= '0;
      res0   <= '0;
      res1   <= '0;
      err_q  <= '0;
    end else begin
      state <= state_n;
      if (take) begin
        own    <= pick;
        last   <= pick;
        core_a <= pick ? a1 : a0;
      end
      if (state == ISSUE)
        cnt <= '0;
      else if (state == WAIT && !core_done)
        cnt <= cnt + 16'd1;
      if (state == WAIT && core_done) begin
        if (own) res1 <= core_result;
        else     res0 <= core_result;
        err_q[own] <= 1'b0;
      end else if (tmo) begin
        if (own) res1 <= '0;
        else     res0 <= '0;
        err_q[own] <= 1'b1;
      end
    end
  end

  // handshake pulses decoded from the state register only
  always_comb begin
    core_init = (state == ISSUE);
    gnt0      = (state == ISSUE) && !own;
    gnt1      = (state == ISSUE) && own;
    valid0    = (state == RETURN) && !own;
    valid1    = (state == RETURN) && own;
    err0      = valid0 && err_q[0];
    err1      = valid1 && err_q[1];
    core_rst  = (state == RETURN) && err_q[own];
  end

endmodule

// File: tb/tb_sqrt_arbiter.sv
// tb_sqrt_arbiter: scenario tasks plus a result scoreboard.
// A behavioural core answers core_init after core_delay cycles.
module tb_sqrt_arbiter;

  localparam int TO = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [15:0] a0 = '0;
  logic [15:0] a1 = '0;
  logic       gnt0, gnt1, valid0, valid1, err0, err1;
  logic [7:0] res0, res1;
  logic       core_init, core_rst, core_done;
  logic [15:0] core_a;
  logic [7:0] core_result;

  typedef struct {
    logic       port;
    logic [7:0] res;
    logic       err;
  } exp_t;

  exp_t sb[$];
  logic gq[$];
  int   total  = 0;
  int   passed = 0;
  int   nvalid = 0;

  int         core_delay = 0;
  int         left = 0;
  logic       pend = 1'b0;
  logic [15:0] a_lat = '0;
  logic       m_done = 1'b0;
  logic [7:0] m_res = '0;
  logic       x_done = 1'b0;
  logic [7:0] x_res = '0;

  assign core_done   = m_done | x_done;
  assign core_result = m_done ? m_res : x_res;

  sqrt_arbiter #(.W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .a0(a0), .a1(a1),
    .gnt0(gnt0), .gnt1(gnt1), .res0(res0), .res1(res1),
    .valid0(valid0), .valid1(valid1), .err0(err0), .err1(err1),
    .core_init(core_init), .core_a(core_a), .core_rst(core_rst),
    .core_done(core_done), .core_result(core_result)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] isqrt(input logic [15:0] x);
    int r = 0;
    while ((r + 1) * (r + 1) <= int'(x)) r++;
    return 8'(r);
  endfunction

  // core model: done pulse core_delay cycles after init, never if <= 0
  always @(negedge clk) begin
    m_done = 1'b0;
    if (rst) pend = 1'b0;
    else begin
      if (pend) begin
        left--;
        if (left == 0) begin
          m_done = 1'b1;
          m_res  = isqrt(a_lat);
          pend   = 1'b0;
        end
      end
      if (core_init && core_delay > 0) begin
        pend  = 1'b1;
        left  = core_delay;
        a_lat = core_a;
      end
    end
  end

  // scoreboard: every valid pops one expected result
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (gnt0 || gnt1)) gq.push_back(gnt1);
    if (!rst && (valid0 || valid1)) begin
      nvalid++;
      total++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected valid0=%0b valid1=%0b required none",
                 valid0, valid1);
      end else begin
        e = sb.pop_front();
        if ({valid1, valid1 ? res1 : res0, valid1 ? err1 : err0, valid0 && valid1}
            !== {e.port, e.res, e.err, 1'b0})
          $display("FAIL sb_result port=%0b res=%0d err=%0b required port=%0b res=%0d err=%0b",
                   valid1, valid1 ? res1 : res0, valid1 ? err1 : err0,
                   e.port, e.res, e.err);
        else passed++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({gnt0, gnt1, valid0, valid1, err0, err1, core_init, core_rst} !== 8'h00)
      $display("FAIL reset_ctl got=%b required=00000000",
               {gnt0, gnt1, valid0, valid1, err0, err1, core_init, core_rst});
    else passed++;
    total++;
    if ({res0, res1, core_a} !== 32'h0)
      $display("FAIL reset_data got=%h required=0", {res0, res1, core_a});
    else passed++;
    rst = 1'b0;
    tick();
    total++;
    if ({gnt0, gnt1, core_init} !== 3'b000)
      $display("FAIL idle_no_req got=%b required=000", {gnt0, gnt1, core_init});
    else passed++;
  endtask

  task automatic test_single();
    int g = -1, v = -1;
    bit v1seen = 0;
    core_delay = 20;
    sb.push_back('{1'b0, 8'd12, 1'b0});
    a0 = 16'd144;
    req0 = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (gnt0 && g < 0) begin g = c; req0 = 1'b0; end
      if (valid0 && v < 0) v = c;
      if (valid1) v1seen = 1;
    end
    total++;
    if (g !== 1) $display("FAIL single_gnt cycle=%0d required=1", g);
    else passed++;
    total++;
    if (v !== 22) $display("FAIL single_valid cycle=%0d required=22", v);
    else passed++;
    total++;
    if (res0 !== 8'd12) $display("FAIL single_hold res0=%0d required=12", res0);
    else passed++;
    total++;
    if (v1seen) $display("FAIL single_no_valid1 seen=1 required=0");
    else passed++;
  endtask

  task automatic test_simultaneous();
    int g0 = -1, g1 = -1, v0 = -1, v1 = -1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    core_delay = 5;
    sb.push_back('{1'b0, 8'd7, 1'b0});
    sb.push_back('{1'b1, 8'd15, 1'b0});
    a0 = 16'd49;
    a1 = 16'd225;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int c = 1; c <= 60 && v1 < 0; c++) begin
      tick();
      if (gnt0 && g0 < 0) begin g0 = c; req0 = 1'b0; end
      if (gnt1 && g1 < 0) begin g1 = c; req1 = 1'b0; end
      if (valid0 && v0 < 0) v0 = c;
      if (valid1 && v1 < 0) v1 = c;
    end
    total++;
    if (g0 !== 1) $display("FAIL tie_first_gnt0 cycle=%0d required=1", g0);
    else passed++;
    total++;
    if (v0 < 0 || g1 !== v0 + 2)
      $display("FAIL tie_gnt1 cycle=%0d required=%0d", g1, v0 + 2);
    else passed++;
    total++;
    if ({res0, res1} !== {8'd7, 8'd15})
      $display("FAIL tie_res res0=%0d res1=%0d required 7 15", res0, res1);
    else passed++;
  endtask

  task automatic test_fairness();
    int k = 0;
    core_delay = 3;
    gq.delete();
    a0 = 16'd100;
    a1 = 16'd81;
    for (int i = 0; i < 6; i++)
      sb.push_back('{1'(i % 2), (i % 2) ? 8'd9 : 8'd10, 1'b0});
    req0 = 1'b1;
    req1 = 1'b1;
    for (int c = 0; c < 200 && k < 6; c++) begin
      tick();
      if (valid0 || valid1) k++;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (4) tick();
    total++;
    if (gq.size() !== 6) $display("FAIL fair_count grants=%0d required=6", gq.size());
    else passed++;
    for (int i = 0; i < 6 && i < gq.size(); i++) begin
      total++;
      if (gq[i] !== 1'(i % 2))
        $display("FAIL fair_order idx=%0d port=%0b required=%0b", i, gq[i], 1'(i % 2));
      else passed++;
    end
  endtask

  task automatic test_timeout();
    int g = -1, v = -1, rc = -1, nrst = 0, ninit = 0;
    logic e1 = 1'b0;
    core_delay = -1;
    sb.push_back('{1'b1, 8'd0, 1'b1});
    a1 = 16'd400;
    req1 = 1'b1;
    for (int c = 1; c <= TO + 10; c++) begin
      tick();
      if (core_init) ninit++;
      if (core_rst) begin nrst++; rc = c; end
      if (gnt1 && g < 0) begin g = c; req1 = 1'b0; end
      if (valid1 && v < 0) begin v = c; e1 = err1; end
    end
    total++;
    if (g < 0 || v - g !== TO + 2)
      $display("FAIL to_latency got=%0d required=%0d", v - g, TO + 2);
    else passed++;
    total++;
    if ({e1, res1} !== {1'b1, 8'd0})
      $display("FAIL to_err err1=%0b res1=%0d required 1 0", e1, res1);
    else passed++;
    total++;
    if (nrst !== 1 || rc !== v)
      $display("FAIL to_core_rst pulses=%0d at=%0d required 1 at %0d", nrst, rc, v);
    else passed++;
    total++;
    if (ninit !== 1) $display("FAIL to_init count=%0d required=1", ninit);
    else passed++;
    core_delay = 4;
    nrst = 0;
    v = -1;
    sb.push_back('{1'b1, 8'd20, 1'b0});
    req1 = 1'b1;
    for (int c = 1; c <= 30 && v < 0; c++) begin
      tick();
      if (gnt1) req1 = 1'b0;
      if (core_rst) nrst++;
      if (valid1) v = c;
    end
    total++;
    if (v < 0 || nrst !== 0)
      $display("FAIL to_recover valid_at=%0d core_rst=%0d required valid, 0", v, nrst);
    else passed++;
  endtask

  task automatic test_collision();
    int g = -1, v = -1, nrst = 0;
    logic e0 = 1'b1;
    core_delay = TO + 1;
    sb.push_back('{1'b0, 8'd13, 1'b0});
    a0 = 16'd169;
    req0 = 1'b1;
    for (int c = 1; c <= TO + 10 && v < 0; c++) begin
      tick();
      if (core_rst) nrst++;
      if (gnt0 && g < 0) begin g = c; req0 = 1'b0; end
      if (valid0) begin v = c; e0 = err0; end
    end
    total++;
    if (g < 0 || v - g !== TO + 2)
      $display("FAIL coll_latency got=%0d required=%0d", v - g, TO + 2);
    else passed++;
    total++;
    if ({e0, nrst != 0} !== 2'b00)
      $display("FAIL coll_err err0=%0b core_rst=%0d required 0 0", e0, nrst);
    else passed++;
  endtask

  task automatic test_reset_mid_wait();
    int base, v = -1;
    bit stray = 0;
    core_delay = -1;
    a0 = 16'd500;
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    total++;
    if ({gnt0, gnt1, valid0, valid1, err0, err1, core_init, core_rst} !== 8'h00 ||
        {res0, res1, core_a} !== 32'h0)
      $display("FAIL rst_wait ctl=%b data=%h required 0",
               {gnt0, gnt1, valid0, valid1, err0, err1, core_init, core_rst},
               {res0, res1, core_a});
    else passed++;
    rst = 1'b0;
    base = nvalid;
    tick();
    x_res = 8'd77;
    x_done = 1'b1;
    tick();
    x_done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (valid0 || valid1) stray = 1;
    end
    total++;
    if (stray || nvalid !== base)
      $display("FAIL stray_done valids=%0d required=0", nvalid - base);
    else passed++;
    core_delay = 3;
    sb.push_back('{1'b1, 8'd0, 1'b0});
    a1 = 16'd0;
    req1 = 1'b1;
    for (int c = 1; c <= 20 && v < 0; c++) begin
      tick();
      if (gnt1) req1 = 1'b0;
      if (valid1) v = c;
    end
    total++;
    if (v < 0) $display("FAIL post_rst_job valid_at=%0d required seen", v);
    else passed++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog sim_time=%0t required finish earlier", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_timeout();
    test_collision();
    test_reset_mid_wait();
    repeat (3) tick();
    total++;
    if (sb.size() !== 0) $display("FAIL sb_leftover pending=%0d required=0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
